// File: rtl/cpu_control_fsm.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Memory-read states stretch on mem_ready; undefined opcodes either halt or act as a NOP.
module cpu_control_fsm #(
    parameter int OPC_W        = 8,
    parameter bit HAS_WAIT     = 1'b1,
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [OPC_W-1:0] IR,
    input  logic [3:0]       CCR_Result,
    input  logic             mem_ready,
    output logic             IR_Load,
    output logic             MAR_Load,
    output logic             PC_Load,
    output logic             PC_Inc,
    output logic             A_Load,
    output logic             B_Load,
    output logic             CCR_Load,
    output logic [2:0]       ALU_Sel,
    output logic [1:0]       Bus1_Sel,
    output logic [1:0]       Bus2_Sel,
    output logic             write,
    output logic             halted
);
    localparam logic [OPC_W-1:0] LDA_IMM = OPC_W'(8'h86), LDB_IMM = OPC_W'(8'h88);
    localparam logic [OPC_W-1:0] LDA_DIR = OPC_W'(8'h87), LDB_DIR = OPC_W'(8'h89);
    localparam logic [OPC_W-1:0] STA_DIR = OPC_W'(8'h96), STB_DIR = OPC_W'(8'h97);
    localparam logic [OPC_W-1:0] ADD  = OPC_W'(8'h42), SUB  = OPC_W'(8'h43);
    localparam logic [OPC_W-1:0] AND_ = OPC_W'(8'h44), OR_  = OPC_W'(8'h45);
    localparam logic [OPC_W-1:0] INCA = OPC_W'(8'h46), INCB = OPC_W'(8'h47);
    localparam logic [OPC_W-1:0] DECA = OPC_W'(8'h48), DECB = OPC_W'(8'h49);
    localparam logic [OPC_W-1:0] BRA  = OPC_W'(8'h20);
    localparam logic [OPC_W-1:0] BMI  = OPC_W'(8'h21), BPL = OPC_W'(8'h22);
    localparam logic [OPC_W-1:0] BEQ  = OPC_W'(8'h23), BNE = OPC_W'(8'h24);
    localparam logic [OPC_W-1:0] BVS  = OPC_W'(8'h25), BVC = OPC_W'(8'h26);
    localparam logic [OPC_W-1:0] BCS  = OPC_W'(8'h27), BCC = OPC_W'(8'h28);

    typedef enum logic [3:0] {
        FETCH0, FETCH1, FETCH2, DECODE,
        IMM0, IMM1, IMM2,
        DIR0, DIR1, DIR2, DIR3,
        ALU0, BR0, BR1, SKIP, HALT
    } state_t;

    state_t           state;
    logic [OPC_W-1:0] op_q;
    logic             rdy, br_hit, is_store;

    assign rdy      = mem_ready | !HAS_WAIT;
    assign is_store = (op_q == STA_DIR) || (op_q == STB_DIR);

    // {N,Z,V,C} = CCR_Result[3:0]
    always_comb begin
        br_hit = 1'b0;
        case (IR)
            BMI: br_hit =  CCR_Result[3];
            BPL: br_hit = !CCR_Result[3];
            BEQ: br_hit =  CCR_Result[2];
            BNE: br_hit = !CCR_Result[2];
            BVS: br_hit =  CCR_Result[1];
            BVC: br_hit = !CCR_Result[1];
            BCS: br_hit =  CCR_Result[0];
            BCC: br_hit = !CCR_Result[0];
            default: br_hit = 1'b0;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= FETCH0;
            op_q  <= '0;
        end else begin
            case (state)
                FETCH0: state <= FETCH1;
                FETCH1: state <= FETCH2;
                FETCH2: if (rdy) state <= DECODE;
                DECODE: begin
                    op_q <= IR;
                    case (IR)
                        LDA_IMM, LDB_IMM:                   state <= IMM0;
                        LDA_DIR, LDB_DIR, STA_DIR, STB_DIR: state <= DIR0;
                        ADD, SUB, AND_, OR_, INCA, INCB, DECA, DECB: state <= ALU0;
                        BRA:                                state <= BR0;
                        BMI, BPL, BEQ, BNE, BVS, BVC, BCS, BCC:
                            state <= br_hit ? BR0 : SKIP;
                        default: state <= ILLEGAL_HALT ? HALT : FETCH0;
                    endcase
                end
                IMM0: state <= IMM1;
                IMM1: state <= IMM2;
                IMM2: if (rdy) state <= FETCH0;
                DIR0: state <= DIR1;
                DIR1: state <= DIR2;
                DIR2: if (rdy) state <= DIR3;
                DIR3: if (is_store || rdy) state <= FETCH0;
                ALU0: state <= FETCH0;
                BR0:  state <= BR1;
                BR1:  if (rdy) state <= FETCH0;
                SKIP: state <= FETCH0;
                HALT: state <= HALT;
                default: state <= FETCH0;
            endcase
        end
    end

    always_comb begin
        IR_Load  = 1'b0;
        MAR_Load = 1'b0;
        PC_Load  = 1'b0;
        PC_Inc   = 1'b0;
        A_Load   = 1'b0;
        B_Load   = 1'b0;
        CCR_Load = 1'b0;
        ALU_Sel  = 3'b000;
        Bus1_Sel = 2'b00;
        Bus2_Sel = 2'b01;
        write    = 1'b0;
        halted   = 1'b0;
        case (state)
            FETCH0, IMM0, DIR0, BR0: MAR_Load = 1'b1;
            FETCH1, IMM1, DIR1, SKIP: PC_Inc = 1'b1;
            FETCH2: begin Bus2_Sel = 2'b10; IR_Load = rdy; end
            IMM2: begin
                Bus2_Sel = 2'b10;
                A_Load   = rdy && (op_q == LDA_IMM);
                B_Load   = rdy && (op_q != LDA_IMM);
            end
            DIR2: begin Bus2_Sel = 2'b10; MAR_Load = rdy; end
            DIR3: begin
                if (is_store) begin
                    Bus1_Sel = (op_q == STA_DIR) ? 2'b01 : 2'b10;
                    write    = 1'b1;
                end else begin
                    Bus2_Sel = 2'b10;
                    A_Load   = rdy && (op_q == LDA_DIR);
                    B_Load   = rdy && (op_q != LDA_DIR);
                end
            end
            ALU0: begin
                // ADD..DECB are 42..49, so low 3 bits minus 2 give the ALU code
                ALU_Sel  = op_q[2:0] - 3'd2;
                Bus1_Sel = 2'b10;
                Bus2_Sel = 2'b00;
                CCR_Load = 1'b1;
                B_Load   = (op_q == INCB) || (op_q == DECB);
                A_Load   = !((op_q == INCB) || (op_q == DECB));
            end
            BR1:  begin Bus2_Sel = 2'b10; PC_Load = rdy; end
            HALT: halted = 1'b1;
            default: ;
        endcase
    end
endmodule
